// File: rtl/code_entry_capture.sv
// ENTER-key capture stage for the combination lock: synchronizes and debounces
// the key, validates the BCD switch digits, and enforces a timed fail lockout.
module code_entry_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic       key_n,
  input  logic       fail,
  input  logic       clear,
  output logic [3:0] digit_a,
  output logic [3:0] digit_b,
  output logic       entry_valid,
  output logic       entry_error,
  output logic       locked_out,
  output logic [1:0] fail_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          locked_q, locked_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]    fails_q, fails_d;
  logic [3:0]    digit_a_q, digit_b_q;
  logic          entry_valid_q, entry_error_q;
  logic          press, accept, digits_ok;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
      else deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  // Lockout sequencing; clear wins over a simultaneous fail.
  always_comb begin
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    fails_d    = fails_q;
    if (locked_q) begin
      if (lock_cnt_q == '0) begin
        locked_d = 1'b0;
        fails_d  = 2'd0;
      end else begin
        lock_cnt_d = lock_cnt_q - LW'(1);
      end
    end else if (clear) begin
      fails_d = 2'd0;
    end else if (fail) begin
      if (fails_q + 2'd1 == 2'(MAX_FAILS)) begin
        locked_d   = 1'b1;
        lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
        fails_d    = 2'(MAX_FAILS);
      end else begin
        fails_d = fails_q + 2'd1;
      end
    end
  end

  assign press     = deb_prev_q & ~deb_q;
  assign accept    = press & ~locked_q;
  assign digits_ok = (sw_a <= 4'd9) && (sw_b <= 4'd9);

  // Key path resets to the released level so reset release never looks like a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      deb_q         <= 1'b1;
      deb_prev_q    <= 1'b1;
      deb_cnt_q     <= '0;
      locked_q      <= 1'b0;
      lock_cnt_q    <= '0;
      fails_q       <= 2'd0;
      digit_a_q     <= 4'd0;
      digit_b_q     <= 4'd0;
      entry_valid_q <= 1'b0;
      entry_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sync1_q       <= key_n;
      sync2_q       <= sync1_q;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_q;
      deb_cnt_q     <= deb_cnt_d;
      locked_q      <= locked_d;
      lock_cnt_q    <= lock_cnt_d;
      fails_q       <= fails_d;
      entry_valid_q <= accept & digits_ok;
      entry_error_q <= accept & ~digits_ok;
      if (accept && digits_ok) begin
        digit_a_q <= sw_a;
        digit_b_q <= sw_b;
      end
    end
  end

  assign digit_a     = digit_a_q;
  assign digit_b     = digit_b_q;
  assign entry_valid = entry_valid_q;
  assign entry_error = entry_error_q;
  assign locked_out  = locked_q;
  assign fail_count  = fails_q;

endmodule

// File: tb/tb_code_entry_capture.sv
// Scoreboard bench for code_entry_capture: stimulus tasks push expected entries,
// an independent monitor pops and compares whenever a strobe appears.
module tb_code_entry_capture;
  localparam int DEB  = 4;
  localparam int MAXF = 3;
  localparam int LOCK = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw_a = 4'd0, sw_b = 4'd0;
  logic       key_n = 1'b1, fail = 1'b0, clear = 1'b0;
  logic [3:0] digit_a, digit_b;
  logic       entry_valid, entry_error, locked_out;
  logic [1:0] fail_count;

  code_entry_capture #(.DEBOUNCE_CYCLES(DEB), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
    .clock(clock), .reset(reset), .sw_a(sw_a), .sw_b(sw_b), .key_n(key_n),
    .fail(fail), .clear(clear), .digit_a(digit_a), .digit_b(digit_b),
    .entry_valid(entry_valid), .entry_error(entry_error),
    .locked_out(locked_out), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n++;

  typedef struct {
    bit         err;
    logic [3:0] a;
    logic [3:0] b;
    int         edge_no;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_errors = 0;

  // Reference model: fail tally, lockout window [lock_start, lock_start+LOCK-1] in edge numbers, last good digits.
  int         model_fc = 0;
  int         lock_start = -1;
  logic [3:0] model_a = 4'd0, model_b = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic bit model_locked(input int e);
    return lock_start >= 0 && e >= lock_start && e <= lock_start + LOCK - 1;
  endfunction

  task automatic normalize(input int e);
    if (lock_start >= 0 && e >= lock_start + LOCK) begin
      model_fc   = 0;
      lock_start = -1;
    end
  endtask

  task automatic model_reset();
    model_fc   = 0;
    lock_start = -1;
    model_a    = 4'd0;
    model_b    = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digit_a"}, digit_a, 0);
    check({tag, "_digit_b"}, digit_b, 0);
    check({tag, "_entry_valid"}, entry_valid, 0);
    check({tag, "_entry_error"}, entry_error, 0);
    check({tag, "_locked_out"}, locked_out, 0);
    check({tag, "_fail_count"}, fail_count, 0);
  endtask

  // Key first sampled low at edge e1: press event is seen at edge e1+5, strobe after edge e1+6.
  task automatic expect_entry(input int e1, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    do @(negedge clock); while (edge_n < e1 + 5);
    #2;
    if (!model_locked(e1 + 5)) begin
      e.edge_no = e1 + 6;
      if (a <= 4'd9 && b <= 4'd9) begin
        e.err   = 1'b0;
        model_a = a;
        model_b = b;
      end else begin
        e.err = 1'b1;
      end
      e.a = model_a;
      e.b = model_b;
      sb.push_back(e);
    end
  endtask

  task automatic press_now(input logic [3:0] a, input logic [3:0] b, input int hold);
    int e1;
    sw_a  = a;
    sw_b  = b;
    key_n = 1'b0;
    e1    = edge_n + 1;
    expect_entry(e1, a, b);
    repeat (hold) @(negedge clock);
    key_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic do_press(input logic [3:0] a, input logic [3:0] b, input int bounces, input int hold);
    @(negedge clock);
    sw_a = a;
    sw_b = b;
    for (int i = 0; i < bounces; i++) begin
      key_n = 1'b0;
      repeat (2) @(negedge clock);
      key_n = 1'b1;
      repeat (2) @(negedge clock);
    end
    press_now(a, b, hold);
  endtask

  task automatic pulse(input bit f, input bit c);
    int fe;
    @(negedge clock);
    fail  = f;
    clear = c;
    fe    = edge_n + 1;
    @(negedge clock);
    fail  = 1'b0;
    clear = 1'b0;
    normalize(fe - 1);
    if (!model_locked(fe - 1)) begin
      if (c) model_fc = 0;
      else if (f) begin
        model_fc++;
        if (model_fc == MAXF) lock_start = fe;
      end
    end
    normalize(fe);
    check("locked_out", locked_out, model_locked(fe));
    check("fail_count", fail_count, model_fc);
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (entry_valid || entry_error) begin
      check("exclusive_strobes", entry_valid & entry_error, 0);
      check("expected_entry_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("strobe_kind_err", entry_error, e.err);
        check("digit_a", digit_a, e.a);
        check("digit_b", digit_b, e.b);
        check("strobe_edge", edge_n, e.edge_no);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_l;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Basic capture, long hold, bounce, and BCD rejection.
    do_press(4'd2, 4'd8, 0, 50);
    do_press(4'd5, 4'd3, 5, 10);
    do_press(4'd1, 4'hA, 0, 5);
    do_press(4'd1, 4'd9, 0, 5);

    // Three fails -> lockout; press during lockout dropped, press right at expiry accepted.
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      if (i < 2) repeat (4) @(negedge clock);
    end
    lock_l = lock_start;
    fork
      begin
        int cnt;
        cnt = 0;
        repeat (80) begin
          if (locked_out) cnt++;
          @(negedge clock);
        end
        check("lockout_cycles", cnt, LOCK);
        normalize(edge_n);
        check("fail_count_after_expiry", fail_count, model_fc);
      end
      begin
        do_press(4'd3, 4'd4, 0, 3);
        while (edge_n < lock_l + 58) @(negedge clock);
        press_now(4'd6, 4'd7, 3);
      end
    join

    // Press whose event cycle is the first locked cycle is discarded.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    fork
      do_press(4'd4, 4'd4, 0, 3);
      begin
        repeat (5) @(negedge clock);
        pulse(1'b1, 1'b0);
      end
    join
    repeat (70) @(negedge clock);
    normalize(edge_n);
    check("fail_count_after_second_lockout", fail_count, model_fc);
    check("locked_after_second_lockout", locked_out, model_locked(edge_n));

    // Clear has priority over a simultaneous fail.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);

    // Reset in the middle of a lockout.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clock);
    #1 reset = 1'b0;
    #1 check_all_zero("rst_lockout");
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Reset in the middle of a debounce, then a full-latency press from release.
    do_press(4'd7, 4'd5, 0, 3);
    @(negedge clock);
    key_n = 1'b0;
    repeat (4) @(negedge clock);
    #1 reset = 1'b0;
    #1 check_all_zero("rst_debounce");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    begin
      int e1;
      e1 = edge_n + 1;
      expect_entry(e1, sw_a, sw_b);
      repeat (3) @(negedge clock);
      key_n = 1'b1;
      repeat (10) @(negedge clock);
    end

    // Randomized mix of presses and checker pulses.
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5)
        do_press(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                 $urandom_range(0, 2), $urandom_range(1, 8));
      else if (op <= 7) pulse(1'b1, 1'b0);
      else if (op == 8) pulse(1'b0, 1'b1);
      else pulse(1'b1, 1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end

    repeat (20) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
